// File: rtl/lbp_hist_if.sv
// lbp_hist_if: LBP code stream in, histogram bin stream out, plus control/status.
interface lbp_hist_if #(parameter int CNT_W = 14);
  logic             start;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [CNT_W-1:0] pix_count;
  logic             sat;
  logic             hist_done;
  modport master (output start, lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
                  input  hist_valid, hist_bin, hist_count, pix_count, sat, hist_done);
  modport slave  (input  start, lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
                  output hist_valid, hist_bin, hist_count, pix_count, sat, hist_done);
endinterface

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin saturating histogram of LBP codes, dumped bin by bin over valid/ready.
module lbp_hist #(parameter int CNT_W = 14) (
  input logic       clk,
  input logic       reset,
  lbp_hist_if.slave io
);
  typedef enum logic [1:0] {IDLE, ACCUM, DUMP, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] bins_q [256];
  logic [CNT_W-1:0] bins_d [256];
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic             sat_q, sat_d;
  logic [7:0]       hist_bin_q, hist_bin_d;
  // start wins over everything, so a restart never leaks partial counts
  always_comb begin
    state_d     = state_q;
    bins_d      = bins_q;
    pix_count_d = pix_count_q;
    sat_d       = sat_q;
    hist_bin_d  = hist_bin_q;
    if (io.start) begin
      state_d     = ACCUM;
      bins_d      = '{default: '0};
      pix_count_d = '0;
      sat_d       = 1'b0;
      hist_bin_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (io.lbp_valid) begin
            if (bins_q[io.lbp_data] == MAX) sat_d = 1'b1;
            else bins_d[io.lbp_data] = bins_q[io.lbp_data] + CNT_W'(1);
            if (pix_count_q == MAX) sat_d = 1'b1;
            else pix_count_d = pix_count_q + CNT_W'(1);
          end
          if (io.finish) begin
            state_d    = DUMP;
            hist_bin_d = '0;
          end
        end
        DUMP: begin
          if (io.hist_ready) begin
            hist_bin_d = hist_bin_q + 8'd1;
            if (hist_bin_q == 8'hFF) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      bins_q      <= '{default: '0};
      pix_count_q <= '0;
      sat_q       <= 1'b0;
      hist_bin_q  <= '0;
    end else begin
      state_q     <= state_d;
      bins_q      <= bins_d;
      pix_count_q <= pix_count_d;
      sat_q       <= sat_d;
      hist_bin_q  <= hist_bin_d;
    end
  end
  assign io.hist_valid = state_q == DUMP;
  assign io.hist_done  = state_q == DONE;
  assign io.hist_bin   = hist_bin_q;
  assign io.hist_count = bins_q[hist_bin_q];
  assign io.pix_count  = pix_count_q;
  assign io.sat        = sat_q;
endmodule
